mcpu_fetch_unit: RTL and testbench
==================================

// Module: mcpu_fetch_unit
// PURPOSE
//   Instruction fetch stage. Holds the packet PC and issues 128-bit packet reads to the icache
//   over f2ic_valid/f2ic_paddr / ic2f_ready/ic2f_packet. Buffers returned packets in a small FIFO
//   and presents them, with their PC, to decode. Handles redirects (branch/exception) without
//   corrupting an icache request that is already in flight.
// PARAMETERS
//   RESET_PC  28'h0000000  packet address fetched first after reset (16-byte packet units)
//   FQ_DEPTH  2            fetch-queue entries (power of 2, >=2)
// PORTS
//   clkrst_core_clk  in   1    core clock; all state on its rising edge
//   clkrst_core_rst  in   1    asynchronous, active-high reset
//   f2ic_valid       out  1    icache request valid
//   f2ic_paddr       out  28   packet address; bit 0 selects the 128-bit half of the 256-bit atom
//   ic2f_ready       in   1    icache response valid this cycle (may be the same cycle as the request)
//   ic2f_packet      in   128  packet data, qualified by ic2f_ready
//   f2d_valid        out  1    queue head valid to decode
//   f2d_packet       out  128  queue head packet
//   f2d_pc           out  28   packet address of the queue head
//   d2f_ready        in   1    decode accepts the head when f2d_valid && d2f_ready
//   pc2f_newpc_valid in   1    redirect strobe (one cycle)
//   pc2f_newpc       in   28   redirect target packet address
// BEHAVIOUR
//   Reset (async assert, sync deassert use): state=FETCH, pc=RESET_PC, queue empty, discard=0;
//     f2ic_valid=0, f2ic_paddr=RESET_PC, f2d_valid=0, f2d_packet=0, f2d_pc=0.
//   f2ic_valid = (state==DRAIN) || (state==FETCH && count<FQ_DEPTH). It depends on registers only,
//     with no comb path from d2f_ready or ic2f_ready.
//   Request rule: once f2ic_valid=1, f2ic_valid and f2ic_paddr stay stable until ic2f_ready=1.
//   FETCH: f2ic_paddr=pc. On ic2f_ready: enqueue {pc, ic2f_packet} and set pc<=pc+1 (mod 2^28,
//     28'hFFFFFFF wraps to 0). Zero-cycle icache gives 1 packet/cycle while the queue is not full.
//   DRAIN: f2ic_paddr=stale address; on ic2f_ready drop the data, set pc<=pending target, go to FETCH.
//   Redirect (pc2f_newpc_valid=1), highest priority:
//     - flush queue (count<=0; f2d_valid=0 next cycle); a same-cycle dequeue is ignored
//     - if no request is outstanding, or ic2f_ready=1 this cycle: drop any response,
//       pc<=pc2f_newpc, stay/go FETCH
//     - else (request outstanding, not ready): target<=pc2f_newpc, go DRAIN
//     - redirect while in DRAIN: target<=pc2f_newpc (last wins), stay DRAIN
//   Queue: enqueue and dequeue may occur in the same cycle (count unchanged). Enqueue never occurs
//     when count==FQ_DEPTH, because f2ic_valid is low then. f2d_* are driven from the head entry.
//     f2d_packet and f2d_pc hold their value while f2d_valid=1 && d2f_ready=0.
//   Reset asserted mid-request: request is abandoned, and the icache must tolerate valid dropping
//     under reset.
// STRUCTURE
//   mcpu_fetch_defs.vh (shared include): PKT_W=128, PADDR_W=28, state encodings ST_FETCH/ST_DRAIN.
//   Sub-module mcpu_fetch_fifo: sync FIFO of {PADDR_W+PKT_W} bits, FQ_DEPTH entries,
//     flush/push/pop, with count, empty and full outputs.
//   Top level: PC/target registers, 2-state FSM, request muxing.
// TESTING
//   1 Reset release with ic always ready and d2f_ready=1 -> f2ic_paddr 0,1,2... one per cycle;
//     f2d_pc follows one cycle later with matching ROM data.
//   2 d2f_ready=0 for 5 cycles -> queue fills to 2 (f2d_pc=0, entry 1 queued) and f2ic_valid drops;
//     after release, PCs 0,1,2 are delivered in order with no loss or duplicate.
//   3 Redirect to 28'h040 at PC 5 with ic ready -> next f2ic_paddr=0x040; the PC-5 packet never
//     reaches decode; f2d_valid=0 for one cycle.
//   4 ic ready held low 3 cycles, redirect 0x100 in cycle 1, then 0x200 in cycle 2 -> paddr stays
//     at the old value until ready; that response is dropped; next request=0x200.
//   5 RESET_PC=28'hFFFFFFE -> fetch order FFFFFFE, FFFFFFF, 0000000.
//   6 Assert reset with 2 entries queued and DRAIN active -> all outputs at reset values
//     immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mcpu_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// mcpu_fetch_unit_pkg
//   Shared widths, FSM state encoding and queue entry layout for the
//   instruction fetch stage.
//   Exports:
//     PKT_W / PADDR_W  packet data width and packet address width
//     FQ_W             width of one fetch-queue entry {pc, packet}
//     fetch_state_e    ST_FETCH / ST_DRAIN
//     fq_entry_t       packed queue entry
//     next_paddr()     sequential packet address, wraps modulo 2^PADDR_W
// ----------------------------------------------------------------------------
package mcpu_fetch_unit_pkg;

    localparam int PKT_W   = 128;
    localparam int PADDR_W = 28;
    localparam int FQ_W    = PADDR_W + PKT_W;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PADDR_W-1:0] pc;
        logic [PKT_W-1:0]   packet;
    } fq_entry_t;

    function automatic logic [PADDR_W-1:0] next_paddr(input logic [PADDR_W-1:0] a);
        return a + PADDR_W'(1);
    endfunction

endpackage

// File: rtl/mcpu_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// mcpu_fetch_unit_if
//   Bundles the fetch stage's three channels:
//     icache request/response : f2ic_valid, f2ic_paddr, ic2f_ready, ic2f_packet
//     decode hand-off         : f2d_valid, f2d_packet, f2d_pc, d2f_ready
//     redirect                : pc2f_newpc_valid, pc2f_newpc
//   master = fetch unit side, slave = environment (icache/decode/PC logic).
// ----------------------------------------------------------------------------
interface mcpu_fetch_unit_if;
    import mcpu_fetch_unit_pkg::*;

    logic               f2ic_valid;
    logic [PADDR_W-1:0] f2ic_paddr;
    logic               ic2f_ready;
    logic [PKT_W-1:0]   ic2f_packet;

    logic               f2d_valid;
    logic [PKT_W-1:0]   f2d_packet;
    logic [PADDR_W-1:0] f2d_pc;
    logic               d2f_ready;

    logic               pc2f_newpc_valid;
    logic [PADDR_W-1:0] pc2f_newpc;

    modport master (
        output f2ic_valid, f2ic_paddr, f2d_valid, f2d_packet, f2d_pc,
        input  ic2f_ready, ic2f_packet, d2f_ready, pc2f_newpc_valid, pc2f_newpc
    );

    modport slave (
        input  f2ic_valid, f2ic_paddr, f2d_valid, f2d_packet, f2d_pc,
        output ic2f_ready, ic2f_packet, d2f_ready, pc2f_newpc_valid, pc2f_newpc
    );

endinterface

// File: rtl/mcpu_fetch_unit_fifo.sv
// ----------------------------------------------------------------------------
// mcpu_fetch_unit_fifo
//   Synchronous fetch queue, DEPTH entries (power of 2) of W bits.
//   Ports:
//     clk_i, rst_i         clock, asynchronous active-high reset
//     flush_i              empty the queue (wins over push/pop)
//     push_i, wdata_i      enqueue (caller guarantees not full)
//     pop_i                dequeue head (caller guarantees not empty)
//     rdata_o              head entry (storage resets to zero)
//     count_o, empty_o, full_o  occupancy
// ----------------------------------------------------------------------------
module mcpu_fetch_unit_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Cleared so the head reads zero out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/mcpu_fetch_unit.sv
// ----------------------------------------------------------------------------
// mcpu_fetch_unit
//   Instruction fetch stage: holds the packet PC, issues 128-bit packet reads
//   to the icache, queues returned packets and presents them to decode with
//   their PC. Redirects never disturb an icache request already in flight: the
//   request is drained (response dropped) before the new target is fetched.
//   Ports:
//     clkrst_core_clk  core clock
//     clkrst_core_rst  asynchronous active-high reset
//     bus              mcpu_fetch_unit_if.master (icache, decode, redirect)
//   Parameters:
//     RESET_PC  first packet address fetched after reset
//     FQ_DEPTH  fetch-queue entries (power of 2, >= 2)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FETCH | requesting pc while the queue has room; responses enqueued
//   ST_DRAIN | waiting out a stale request; response dropped, then pc<=target
// ----------------------------------------------------------------------------
module mcpu_fetch_unit
    import mcpu_fetch_unit_pkg::*;
#(
    parameter logic [PADDR_W-1:0] RESET_PC = '0,
    parameter int                 FQ_DEPTH = 2
) (
    input  logic              clkrst_core_clk,
    input  logic              clkrst_core_rst,
    mcpu_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    fetch_state_e       state_q, state_d;
    logic [PADDR_W-1:0] pc_q, pc_d;
    logic [PADDR_W-1:0] target_q, target_d;
    logic               run_q;

    logic               fq_flush, fq_push, fq_pop;
    fq_entry_t          fq_wdata, fq_rdata;
    logic [CNT_W-1:0]   fq_count;
    logic               fq_empty, fq_full;

    logic               req_valid;
    logic               ic_done;

    // run_q keeps the request low while reset is held and for the first cycle
    // after release, so f2ic_valid is a pure function of registers.
    assign req_valid = run_q && ((state_q == ST_DRAIN) ||
                                 (state_q == ST_FETCH && fq_count < CNT_W'(FQ_DEPTH)));
    assign ic_done   = req_valid && bus.ic2f_ready;
    assign fq_wdata  = '{pc: pc_q, packet: bus.ic2f_packet};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        fq_flush = 1'b0;
        fq_push  = 1'b0;
        fq_pop   = 1'b0;
        if (bus.pc2f_newpc_valid) begin
            fq_flush = 1'b1;
            if (!req_valid || bus.ic2f_ready) begin
                // Nothing in flight (or it completes now and is dropped).
                pc_d    = bus.pc2f_newpc;
                state_d = ST_FETCH;
            end else begin
                target_d = bus.pc2f_newpc;
                state_d  = ST_DRAIN;
            end
        end else begin
            fq_pop = !fq_empty && bus.d2f_ready;
            case (state_q)
                ST_FETCH: begin
                    if (ic_done && !fq_full) begin
                        fq_push = 1'b1;
                        pc_d    = next_paddr(pc_q);
                    end
                end
                ST_DRAIN: begin
                    if (ic_done) begin
                        pc_d    = target_q;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            run_q    <= 1'b1;
        end
    end

    mcpu_fetch_unit_fifo #(
        .W     (FQ_W),
        .DEPTH (FQ_DEPTH),
        .CNT_W (CNT_W)
    ) u_fq (
        .clk_i   (clkrst_core_clk),
        .rst_i   (clkrst_core_rst),
        .flush_i (fq_flush),
        .push_i  (fq_push),
        .wdata_i (fq_wdata),
        .pop_i   (fq_pop),
        .rdata_o (fq_rdata),
        .count_o (fq_count),
        .empty_o (fq_empty),
        .full_o  (fq_full)
    );

    // In DRAIN pc_q still holds the stale address, so paddr is always pc_q.
    assign bus.f2ic_valid = req_valid;
    assign bus.f2ic_paddr = pc_q;
    assign bus.f2d_valid  = !fq_empty;
    assign bus.f2d_packet = fq_rdata.packet;
    assign bus.f2d_pc     = fq_rdata.pc;

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
module tb_mcpu_fetch_unit;
    import mcpu_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               ic_rdy   = 1'b1;
    logic               d_rdy    = 1'b1;
    logic               redir    = 1'b0;
    logic [PADDR_W-1:0] redir_pc = '0;

    int checks   = 0;
    int failures = 0;

    logic [PADDR_W-1:0] exp_req[$];
    logic [PADDR_W-1:0] exp_dec[$];
    logic [PADDR_W-1:0] exp2_dec[$];

    function automatic logic [PKT_W-1:0] rom(input logic [PADDR_W-1:0] a);
        return {a, 4'h5, ~a, 4'hA, a ^ 28'h5A5A5A5, 4'h3, {a[13:0], a[27:14]}, 4'hC};
    endfunction

    mcpu_fetch_unit_if bus ();
    mcpu_fetch_unit_if bus2 ();

    assign bus.ic2f_ready       = ic_rdy;
    assign bus.ic2f_packet      = rom(bus.f2ic_paddr);
    assign bus.d2f_ready        = d_rdy;
    assign bus.pc2f_newpc_valid = redir;
    assign bus.pc2f_newpc       = redir_pc;

    assign bus2.ic2f_ready       = 1'b1;
    assign bus2.ic2f_packet      = rom(bus2.f2ic_paddr);
    assign bus2.d2f_ready        = 1'b1;
    assign bus2.pc2f_newpc_valid = 1'b0;
    assign bus2.pc2f_newpc       = '0;

    mcpu_fetch_unit #(.RESET_PC(28'h0000000), .FQ_DEPTH(2)) dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .bus             (bus)
    );

    mcpu_fetch_unit #(.RESET_PC(28'hFFFFFFE), .FQ_DEPTH(2)) dut2 (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .bus             (bus2)
    );

    // Scoreboard monitors: pop and compare whenever the DUT completes a transfer.
    always @(negedge clk) begin
        logic [PADDR_W-1:0] e;
        if (bus.f2ic_valid && bus.ic2f_ready && exp_req.size() > 0) begin
            e = exp_req.pop_front();
            checks++;
            if (bus.f2ic_paddr !== e) begin
                failures++;
                $display("FAIL req_paddr actual=%h expected=%h", bus.f2ic_paddr, e);
            end
        end
        if (bus.f2d_valid && bus.d2f_ready && !bus.pc2f_newpc_valid && exp_dec.size() > 0) begin
            e = exp_dec.pop_front();
            checks++;
            if (bus.f2d_pc !== e || bus.f2d_packet !== rom(e)) begin
                failures++;
                $display("FAIL dec_pkt actual_pc=%h expected_pc=%h actual_pkt=%h expected_pkt=%h",
                         bus.f2d_pc, e, bus.f2d_packet, rom(e));
            end
        end
        if (bus2.f2d_valid && exp2_dec.size() > 0) begin
            e = exp2_dec.pop_front();
            checks++;
            if (bus2.f2d_pc !== e || bus2.f2d_packet !== rom(e)) begin
                failures++;
                $display("FAIL dec2_pkt actual_pc=%h expected_pc=%h", bus2.f2d_pc, e);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drain(input string nm, input int max_cyc);
        int k = 0;
        int left;
        left = exp_req.size() + exp_dec.size() + exp2_dec.size();
        while (left != 0 && k < max_cyc) begin
            cyc();
            k++;
            left = exp_req.size() + exp_dec.size() + exp2_dec.size();
        end
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL %s_drain remaining=%0d expected=0", nm, left);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        redir = 1'b0;
        exp_req.delete();
        exp_dec.delete();
        exp2_dec.delete();
        cyc(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit found;

        // 1: streaming from reset, zero-cycle icache
        ic_rdy = 1'b1; d_rdy = 1'b1;
        do_reset();
        chk("rst_f2ic_valid", bus.f2ic_valid, 0);
        chk("rst_f2ic_paddr", bus.f2ic_paddr, 0);
        chk("rst_f2d_valid",  bus.f2d_valid, 0);
        chk("rst_f2d_packet", bus.f2d_packet, 0);
        chk("rst_f2d_pc",     bus.f2d_pc, 0);
        chk("rst2_f2ic_paddr", bus2.f2ic_paddr, 28'hFFFFFFE);
        for (int i = 0; i < 8; i++) begin
            exp_req.push_back(PADDR_W'(i));
            exp_dec.push_back(PADDR_W'(i));
        end
        rst = 1'b0;
        cyc();
        chk("t1_c1_f2ic_valid", bus.f2ic_valid, 1);
        chk("t1_c1_f2d_valid",  bus.f2d_valid, 0);
        cyc();
        chk("t1_c2_paddr",     bus.f2ic_paddr, 1);
        chk("t1_c2_f2d_valid", bus.f2d_valid, 1);
        chk("t1_c2_f2d_pc",    bus.f2d_pc, 0);
        drain("t1", 40);

        // 2: decode stall fills the queue, then releases in order
        ic_rdy = 1'b1; d_rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_req.push_back(PADDR_W'(i));
            exp_dec.push_back(PADDR_W'(i));
        end
        rst = 1'b0;
        cyc(5);
        chk("t2_f2d_valid",   bus.f2d_valid, 1);
        chk("t2_f2d_pc",      bus.f2d_pc, 0);
        chk("t2_f2d_packet",  bus.f2d_packet, rom(28'h0));
        chk("t2_f2ic_valid",  bus.f2ic_valid, 0);
        chk("t2_f2ic_paddr",  bus.f2ic_paddr, 2);
        d_rdy = 1'b1;
        drain("t2", 40);

        // 3: redirect coincident with a completing request at PC 5
        ic_rdy = 1'b1; d_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) exp_req.push_back(PADDR_W'(i));
        for (int i = 0; i < 3; i++) exp_req.push_back(PADDR_W'(28'h040 + i));
        for (int i = 0; i < 4; i++) exp_dec.push_back(PADDR_W'(i));
        for (int i = 0; i < 3; i++) exp_dec.push_back(PADDR_W'(28'h040 + i));
        rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            if (bus.f2ic_paddr == 28'd5) found = 1'b1;
        end
        chk("t3_reach_pc5", found, 1);
        redir = 1'b1; redir_pc = 28'h040;
        cyc();
        redir = 1'b0;
        chk("t3_f2d_valid_gap", bus.f2d_valid, 0);
        chk("t3_paddr_target",  bus.f2ic_paddr, 28'h040);
        cyc();
        chk("t3_f2d_valid_back", bus.f2d_valid, 1);
        chk("t3_f2d_pc",         bus.f2d_pc, 28'h040);
        drain("t3", 40);

        // 4: redirects while a request is stalled; last target wins
        ic_rdy = 1'b0; d_rdy = 1'b1;
        do_reset();
        exp_req.push_back(28'h000);
        for (int i = 0; i < 3; i++) begin
            exp_req.push_back(PADDR_W'(28'h200 + i));
            exp_dec.push_back(PADDR_W'(28'h200 + i));
        end
        rst = 1'b0;
        cyc();
        chk("t4_req_out", bus.f2ic_valid, 1);
        redir = 1'b1; redir_pc = 28'h100;
        cyc();
        chk("t4_c1_paddr", bus.f2ic_paddr, 0);
        chk("t4_c1_valid", bus.f2ic_valid, 1);
        redir_pc = 28'h200;
        cyc();
        redir = 1'b0;
        cyc();
        chk("t4_c3_paddr", bus.f2ic_paddr, 0);
        chk("t4_c3_valid", bus.f2ic_valid, 1);
        ic_rdy = 1'b1;
        cyc();
        chk("t4_new_paddr",  bus.f2ic_paddr, 28'h200);
        chk("t4_f2d_valid",  bus.f2d_valid, 0);
        drain("t4", 40);

        // 5: address wrap from RESET_PC=FFFFFFE
        do_reset();
        exp2_dec.push_back(28'hFFFFFFE);
        exp2_dec.push_back(28'hFFFFFFF);
        exp2_dec.push_back(28'h0000000);
        exp2_dec.push_back(28'h0000001);
        rst = 1'b0;
        cyc();
        chk("t5_paddr0", bus2.f2ic_paddr, 28'hFFFFFFE);
        cyc();
        chk("t5_paddr1", bus2.f2ic_paddr, 28'hFFFFFFF);
        chk("t5_f2d_pc", bus2.f2d_pc, 28'hFFFFFFE);
        cyc();
        chk("t5_paddr2", bus2.f2ic_paddr, 28'h0000000);
        drain("t5", 20);

        // 6a: reset with a full queue
        ic_rdy = 1'b1; d_rdy = 1'b0;
        do_reset();
        rst = 1'b0;
        cyc(4);
        chk("t6_pre_full_valid", bus.f2ic_valid, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6a_f2ic_valid", bus.f2ic_valid, 0);
        chk("t6a_f2d_valid",  bus.f2d_valid, 0);
        chk("t6a_f2d_pc",     bus.f2d_pc, 0);
        chk("t6a_f2d_packet", bus.f2d_packet, 0);
        chk("t6a_f2ic_paddr", bus.f2ic_paddr, 0);

        // 6b: reset while draining a stale request
        cyc();
        ic_rdy = 1'b0; d_rdy = 1'b1;
        rst = 1'b0;
        cyc();
        redir = 1'b1; redir_pc = 28'h300;
        cyc();
        redir = 1'b0;
        chk("t6b_drain_paddr", bus.f2ic_paddr, 0);
        chk("t6b_drain_valid", bus.f2ic_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6b_f2ic_valid", bus.f2ic_valid, 0);
        chk("t6b_f2ic_paddr", bus.f2ic_paddr, 0);
        chk("t6b_f2d_valid",  bus.f2d_valid, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            exp_req.push_back(PADDR_W'(i));
            exp_dec.push_back(PADDR_W'(i));
        end
        ic_rdy = 1'b1;
        rst = 1'b0;
        cyc();
        chk("t6_restart_paddr", bus.f2ic_paddr, 0);
        chk("t6_restart_valid", bus.f2ic_valid, 1);
        drain("t6", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
